// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: geometry, FSM states,
// register offsets and source indices.
package irq_arbiter_pkg;

  localparam int N_SRC = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ISR  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] REG_PEND  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_CAUSE = 2'd3;

  localparam int SRC_TIMER   = 0;
  localparam int SRC_UART_RX = 1;
  localparam int SRC_UART_TX = 2;

endpackage

// File: rtl/irq_arbiter_if.sv
// Peripheral bus port of the interrupt arbiter (word-decoded, 4-bit byte offset).
interface irq_arbiter_if;

  logic        sel;
  logic        rd;
  logic        wr;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, rd, wr, addr, wdata, input rdata);
  modport slave  (input sel, rd, wr, addr, wdata, output rdata);

endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// Combinational lowest-index-first priority encoder with one-hot grant and valid flag.
module prio_enc
  import irq_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id,
  output logic [N_SRC-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign onehot[gi] = req[gi];
      end else begin : g_upper
        assign onehot[gi] = req[gi] & ~(|req[gi-1:0]);
      end
    end
  endgenerate

  assign valid = |req;

  // onehot has at most one bit set, so OR-ing the indices yields the winner
  always_comb begin
    id = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (onehot[i]) begin
        id = id | i[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending bits, mask/global enable, fixed priority,
// and an IDLE/ISR/GAP sequencer driving a one-cycle take pulse to Control.
module irq_arbiter
  import irq_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic               kernel,
  irq_arbiter_if.slave       bus,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [N_SRC-1:0]   irq_ack
);

  state_t             state_reg, state_next;
  logic [N_SRC-1:0]   src_q_reg;
  logic [N_SRC-1:0]   pend_reg, pend_next;
  logic [N_SRC-1:0]   mask_reg, mask_next;
  logic               gie_reg, gie_next;
  logic               cause_valid_reg, cause_valid_next;
  logic [ID_W-1:0]    cause_id_reg, cause_id_next;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   win_onehot;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               take;
  logic               wr_hit;
  logic [1:0]         reg_sel;
  logic [N_SRC-1:0]   w1c;
  logic [31:0]        rdata_int;
  logic               unused_bus_bits;

  assign rise     = irq_src & ~src_q_reg;
  assign eligible = pend_reg & mask_reg;
  assign wr_hit   = bus.sel & bus.wr;
  assign reg_sel  = bus.addr[3:2];

  assign unused_bus_bits = ^{bus.wdata[31:N_SRC], bus.addr[1:0]};

  prio_enc u_prio_enc (
    .req    (eligible),
    .valid  (win_valid),
    .id     (win_id),
    .onehot (win_onehot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      src_q_reg       <= '0;
      pend_reg        <= '0;
      mask_reg        <= '0;
      gie_reg         <= 1'b0;
      cause_valid_reg <= 1'b0;
      cause_id_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      src_q_reg       <= irq_src;
      pend_reg        <= pend_next;
      mask_reg        <= mask_next;
      gie_reg         <= gie_next;
      cause_valid_reg <= cause_valid_next;
      cause_id_reg    <= cause_id_next;
    end
  end

  // Take is a Mealy decision of IDLE; kernel=1 blocks it in every state.
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    irq        = 1'b0;
    irq_id     = '0;
    irq_ack    = '0;
    case (state_reg)
      S_IDLE: begin
        if (gie_reg && !kernel && win_valid) begin
          take       = 1'b1;
          irq        = 1'b1;
          irq_id     = win_id;
          irq_ack    = win_onehot;
          state_next = S_ISR;
        end
      end
      S_ISR: begin
        if (!kernel) begin
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // A new rising edge always beats a clear from either W1C or a take.
  always_comb begin
    mask_next        = mask_reg;
    gie_next         = gie_reg;
    cause_valid_next = cause_valid_reg;
    cause_id_next    = cause_id_reg;
    w1c              = '0;
    if (wr_hit) begin
      case (reg_sel)
        REG_PEND: w1c       = bus.wdata[N_SRC-1:0];
        REG_MASK: mask_next = bus.wdata[N_SRC-1:0];
        REG_CTRL: gie_next  = bus.wdata[0];
        default:  ;
      endcase
    end
    if (take) begin
      cause_valid_next = 1'b1;
      cause_id_next    = win_id;
    end
    pend_next = (pend_reg & ~w1c & ~(take ? win_onehot : '0)) | rise;
  end

  always_comb begin
    rdata_int = '0;
    if (bus.sel && bus.rd) begin
      case (reg_sel)
        REG_PEND:  rdata_int = {{(32-N_SRC){1'b0}}, pend_reg};
        REG_MASK:  rdata_int = {{(32-N_SRC){1'b0}}, mask_reg};
        REG_CTRL:  rdata_int = {31'd0, gie_reg};
        REG_CAUSE: rdata_int = {cause_valid_reg, {(31-ID_W){1'b0}}, cause_id_reg};
        default:   rdata_int = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_int;

endmodule
